// File: rtl/mips_cpu_state_sequencer.sv
// Multi-cycle MIPS control sequencer: HALT/FETCH/DECODE/EXEC1/EXEC2 with memory and
// HI/LO stalls, retire pulse, and active-cycle / retired-instruction counters.
module mips_cpu_state_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        waitrequest,
    input  logic [5:0]  opcode,
    input  logic [5:0]  fncode,
    input  logic [4:0]  regimm,
    input  logic [31:0] pc,
    input  logic        muldiv_busy,
    output logic [2:0]  state,
    output logic        active,
    output logic        instr_done,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC1  = 3'd3,
        ST_EXEC2  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        halted_r;
    logic        halted_next_s;
    logic        active_r;
    logic        stall_s;
    logic        done_s;
    logic [31:0] cycle_count_r;
    logic [31:0] instr_count_r;

    function automatic logic is_load(input logic [5:0] op);
        return (op >= 6'h20) && (op <= 6'h26);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == 6'h28) || (op == 6'h29) || (op == 6'h2b);
    endfunction

    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'h00) &&
               (((fn >= 6'h10) && (fn <= 6'h13)) || ((fn >= 6'h18) && (fn <= 6'h1b)));
    endfunction

    // Linking REGIMM branches need a second exec cycle to write $ra.
    function automatic logic is_link_branch(input logic [5:0] op, input logic [4:0] rim);
        return (op == 6'h01) && (rim >= 5'h02);
    endfunction

    // Next-state, stall and retire decode.
    always_comb begin
        state_next_s  = state_r;
        halted_next_s = halted_r;
        stall_s       = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            ST_HALT: begin
                if (halted_r) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pc == 32'h0000_0000) begin
                    state_next_s  = ST_HALT;
                    halted_next_s = 1'b1;
                end else if (waitrequest) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next_s = ST_EXEC1;
            end
            ST_EXEC1: begin
                stall_s = ((is_load(opcode) || is_store(opcode)) && waitrequest) ||
                          (is_muldiv(opcode, fncode) && muldiv_busy);
                if (stall_s) begin
                    state_next_s = ST_EXEC1;
                end else if (is_load(opcode) || is_link_branch(opcode, regimm)) begin
                    state_next_s = ST_EXEC2;
                end else begin
                    state_next_s = ST_FETCH;
                    done_s       = 1'b1;
                end
            end
            ST_EXEC2: begin
                state_next_s = ST_FETCH;
                done_s       = 1'b1;
            end
            default: begin
                state_next_s  = ST_HALT;
                halted_next_s = 1'b1;
            end
        endcase
    end

    // State, sticky halt flag, active flag and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_HALT;
            halted_r      <= 1'b0;
            active_r      <= 1'b0;
            cycle_count_r <= 32'd0;
            instr_count_r <= 32'd0;
        end else begin
            state_r  <= state_next_s;
            halted_r <= halted_next_s;
            active_r <= (state_next_s != ST_HALT);
            if (active_r) begin
                cycle_count_r <= cycle_count_r + 32'd1;
            end
            if (done_s) begin
                instr_count_r <= instr_count_r + 32'd1;
            end
        end
    end

    assign state       = state_r;
    assign active      = active_r;
    assign instr_done  = done_s;
    assign cycle_count = cycle_count_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Table-driven bench for mips_cpu_state_sequencer with a scoreboard queue and
// hand-written halt, counter-wrap and asynchronous-reset sequences.
module tb_mips_cpu_state_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        waitrequest;
    logic [5:0]  opcode;
    logic [5:0]  fncode;
    logic [4:0]  regimm;
    logic [31:0] pc;
    logic        muldiv_busy;
    logic [2:0]  state;
    logic        active;
    logic        instr_done;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    localparam logic [31:0] PCV = 32'hBFC0_0000;

    typedef struct packed {
        logic        wr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rim;
        logic        mb;
        logic [31:0] pcv;
        logic [2:0]  st;
        logic        done;
    } vec_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        act;
        logic        done;
        logic [31:0] cc;
        logic [31:0] ic;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_cc;
    logic [31:0] exp_ic;

    mips_cpu_state_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .waitrequest (waitrequest),
        .opcode      (opcode),
        .fncode      (fncode),
        .regimm      (regimm),
        .pc          (pc),
        .muldiv_busy (muldiv_busy),
        .state       (state),
        .active      (active),
        .instr_done  (instr_done),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic wr, input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] rim, input logic mb, input logic [31:0] pcv,
                                input logic [2:0] st, input logic done);
        vec_t v;
        v.wr = wr; v.op = op; v.fn = fn; v.rim = rim; v.mb = mb;
        v.pcv = pcv; v.st = st; v.done = done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".state"}, 32'(state), 32'd0);
        chk({tag, ".active"}, 32'(active), 32'd0);
        chk({tag, ".done"}, 32'(instr_done), 32'd0);
        chk({tag, ".cycles"}, cycle_count, 32'd0);
        chk({tag, ".instrs"}, instr_count, 32'd0);
    endtask

    // Drive one cycle of inputs at negedge, queue the expectation, compare just after.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        waitrequest = v.wr;
        opcode      = v.op;
        fncode      = v.fn;
        regimm      = v.rim;
        muldiv_busy = v.mb;
        pc          = v.pcv;
        e.st   = v.st;
        e.act  = (v.st != 3'd0);
        e.done = v.done;
        e.cc   = exp_cc;
        e.ic   = exp_ic;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({tag, ".state"}, 32'(state), 32'(e.st));
        chk({tag, ".active"}, 32'(active), 32'(e.act));
        chk({tag, ".done"}, 32'(instr_done), 32'(e.done));
        chk({tag, ".cycles"}, cycle_count, e.cc);
        chk({tag, ".instrs"}, instr_count, e.ic);
        if (e.act) exp_cc = exp_cc + 32'd1;
        if (e.done) exp_ic = exp_ic + 32'd1;
    endtask

    initial begin
        reset_n     = 1'b0;
        waitrequest = 1'b0;
        opcode      = 6'h09;
        fncode      = 6'h00;
        regimm      = 5'h00;
        muldiv_busy = 1'b0;
        pc          = PCV;
        exp_cc      = 32'd0;
        exp_ic      = 32'd0;

        // ADDIU: post-reset HALT, then FETCH, DECODE, EXEC1 (retire)
        tbl.push_back(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd0, 1'b0));
        tbl.push_back(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        tbl.push_back(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd3, 1'b1));
        // LW: two fetch wait states, three exec wait states, then EXEC2
        tbl.push_back(mk(1'b1, 6'h23, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b1, 6'h23, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h23, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b1, 6'h23, 6'h00, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b1, 6'h23, 6'h00, 5'h00, 1'b0, PCV, 3'd3, 1'b0));
        tbl.push_back(mk(1'b0, 6'h23, 6'h00, 5'h00, 1'b0, PCV, 3'd3, 1'b0));
        tbl.push_back(mk(1'b1, 6'h23, 6'h00, 5'h00, 1'b0, PCV, 3'd4, 1'b1));
        // BGEZAL visits EXEC2
        tbl.push_back(mk(1'b0, 6'h01, 6'h00, 5'h11, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h01, 6'h00, 5'h11, 1'b0, PCV, 3'd2, 1'b0));
        tbl.push_back(mk(1'b0, 6'h01, 6'h00, 5'h11, 1'b0, PCV, 3'd3, 1'b0));
        tbl.push_back(mk(1'b0, 6'h01, 6'h00, 5'h11, 1'b0, PCV, 3'd4, 1'b1));
        // BLTZ (regimm 0) does not
        tbl.push_back(mk(1'b0, 6'h01, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h01, 6'h00, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        tbl.push_back(mk(1'b0, 6'h01, 6'h00, 5'h00, 1'b0, PCV, 3'd3, 1'b1));
        // MULT: muldiv busy 10 cycles, waitrequest irrelevant -> EXEC1 held 11 cycles
        tbl.push_back(mk(1'b0, 6'h00, 6'h18, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h00, 6'h18, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1'b1, 6'h00, 6'h18, 5'h00, 1'b1, PCV, 3'd3, 1'b0));
        tbl.push_back(mk(1'b1, 6'h00, 6'h18, 5'h00, 1'b0, PCV, 3'd3, 1'b1));
        // MFLO: two busy cycles
        tbl.push_back(mk(1'b0, 6'h00, 6'h12, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h00, 6'h12, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(1'b0, 6'h00, 6'h12, 5'h00, 1'b1, PCV, 3'd3, 1'b0));
        tbl.push_back(mk(1'b0, 6'h00, 6'h12, 5'h00, 1'b0, PCV, 3'd3, 1'b1));
        // ADDU ignores both busy signals
        tbl.push_back(mk(1'b0, 6'h00, 6'h21, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h00, 6'h21, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        tbl.push_back(mk(1'b1, 6'h00, 6'h21, 5'h00, 1'b1, PCV, 3'd3, 1'b1));
        // SW ignores muldiv_busy
        tbl.push_back(mk(1'b0, 6'h2b, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h2b, 6'h00, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        tbl.push_back(mk(1'b0, 6'h2b, 6'h10, 5'h00, 1'b1, PCV, 3'd3, 1'b1));
        // Undefined opcode retires from EXEC1 without stalling
        tbl.push_back(mk(1'b0, 6'h3f, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h3f, 6'h00, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        tbl.push_back(mk(1'b1, 6'h3f, 6'h00, 5'h00, 1'b1, PCV, 3'd3, 1'b1));
        // LB (lowest load opcode) goes through EXEC2
        tbl.push_back(mk(1'b0, 6'h20, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0));
        tbl.push_back(mk(1'b0, 6'h20, 6'h00, 5'h00, 1'b0, PCV, 3'd2, 1'b0));
        tbl.push_back(mk(1'b0, 6'h20, 6'h00, 5'h00, 1'b0, PCV, 3'd3, 1'b0));
        tbl.push_back(mk(1'b0, 6'h20, 6'h00, 5'h00, 1'b0, PCV, 3'd4, 1'b1));

        repeat (2) @(posedge clk);
        #2;
        chk_reset("reset");
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("t%0d", i));

        // FETCH at pc=0 with waitrequest=1 -> terminal HALT, counters frozen
        apply(mk(1'b1, 6'h09, 6'h00, 5'h00, 1'b0, 32'h0000_0000, 3'd1, 1'b0), "halt_fetch");
        for (int i = 0; i < 20; i++)
            apply(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd0, 1'b0), "halt_hold");

        // Reset pulse restarts from HALT into FETCH
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        exp_cc = 32'd0;
        exp_ic = 32'd0;
        chk_reset("reset2");
        @(posedge clk);
        #2 reset_n = 1'b1;
        apply(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd0, 1'b0), "restart_halt");

        // instr_count wrap after a backdoor preload
        apply(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0), "wrap_fetch");
        apply(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd2, 1'b0), "wrap_decode");
        @(posedge clk);
        #2 force dut.instr_count_r = 32'hFFFF_FFFF;
        #1 release dut.instr_count_r;
        exp_ic = 32'hFFFF_FFFF;
        apply(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd3, 1'b1), "wrap_exec1");

        // Stalled SW interrupted by reset mid-EXEC1
        apply(mk(1'b0, 6'h2b, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0), "sw_fetch");
        apply(mk(1'b1, 6'h2b, 6'h00, 5'h00, 1'b0, PCV, 3'd2, 1'b0), "sw_decode");
        apply(mk(1'b1, 6'h2b, 6'h00, 5'h00, 1'b0, PCV, 3'd3, 1'b0), "sw_stall");
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        exp_cc = 32'd0;
        exp_ic = 32'd0;
        chk_reset("reset_mid_stall");
        @(posedge clk);
        #2 reset_n = 1'b1;
        apply(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd0, 1'b0), "post_halt");
        apply(mk(1'b0, 6'h09, 6'h00, 5'h00, 1'b0, PCV, 3'd1, 1'b0), "post_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_cpu_state_sequencer.md
MIPS_CPU_STATE_SEQUENCER -- requirements
Module: mips_cpu_state_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising-edge) and reset_n (active-low).
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- waitrequest  in  1  memory busy, Avalon-style
- opcode  in  6  IR[31:26]
- fncode  in  6  IR[5:0]
- regimm  in  5  IR[20:16]
- pc  in  32  current program counter
- muldiv_busy  in  1  HI/LO unit still computing
- state  out  3  0=HALT, 1=FETCH, 2=DECODE, 3=EXEC1, 4=EXEC2; drives the controller
- active  out  1  CPU running
- instr_done  out  1  one-cycle pulse per retired instruction
- cycle_count  out  32  cycles spent active
- instr_count  out  32  retired instructions

Function
REQ-003 state SHALL be a registered output that changes only on clk rising edges or on reset assertion.
REQ-004 An internal sticky flag, halted, SHALL distinguish post-reset HALT (halted=0) from terminal HALT (halted=1).
REQ-005 In HALT with halted=0, the next state SHALL be FETCH.
REQ-006 In HALT with halted=1, the block SHALL hold HALT until reset.
REQ-007 In FETCH with pc==32'h0, the next state SHALL be HALT and halted SHALL be set, regardless of waitrequest.
REQ-008 In FETCH with pc!=0, the block SHALL stay in FETCH while waitrequest=1 and SHALL go to DECODE on the first cycle waitrequest=0.
REQ-009 DECODE SHALL go to EXEC1 unconditionally after one cycle.
REQ-010 EXEC1 SHALL stall while waitrequest=1 for memory ops: opcode 6'h20-6'h26 (loads) and 6'h28, 6'h29, 6'h2b (stores).
REQ-011 EXEC1 SHALL stall while muldiv_busy=1 for opcode 0 with fncode 6'h10-6'h13 or 6'h18-6'h1b.
REQ-012 When not stalled, EXEC1 SHALL go to EXEC2 for loads (6'h20-6'h26) and for opcode 1 with regimm>=2 (BLTZAL/BGEZAL).
REQ-013 When not stalled, EXEC1 SHALL go to FETCH for every other opcode, including undefined ones.
REQ-014 EXEC2 SHALL go to FETCH unconditionally after one cycle.
REQ-015 Any state encoding 5-7 SHALL go to HALT with halted set.
REQ-016 instr_done SHALL be a combinational pulse, high in the final exec cycle: EXEC1 unstalled going to FETCH, or EXEC2.
REQ-017 instr_done SHALL be high for exactly one cycle per instruction.
REQ-018 instr_count SHALL increment by 1 on each clock edge where instr_done=1, wrapping 32'hFFFFFFFF to 0.
REQ-019 active SHALL be high iff state != HALT.
REQ-020 cycle_count SHALL increment on every edge where active=1, wrapping 32'hFFFFFFFF to 0; it SHALL freeze in HALT.
REQ-021 When waitrequest and muldiv_busy are asserted together, only the stall condition relevant to the current opcode SHALL apply; an irrelevant busy signal SHALL be ignored.
REQ-022 Total latency SHALL be 4 cycles for a non-memory, non-muldiv instruction with zero wait states (FETCH, DECODE, EXEC1, FETCH), and 5 cycles for a load.

Reset
REQ-023 While reset_n=0, the block SHALL hold state=0, halted=0, active=0, instr_done=0, cycle_count=0, instr_count=0.
REQ-024 Reset assertion SHALL take effect immediately, including mid-instruction and mid-stall; no partial instruction SHALL be counted.
REQ-025 On the first rising edge after reset_n rises, state SHALL become FETCH (1).

Verification
REQ-026 Reset release, pc=32'hBFC00000, waitrequest=0, opcode=6'h9 (ADDIU) -> state sequence 0,1,2,3,1; instr_done high in the EXEC1 cycle; instr_count=1; cycle_count=3 at the second FETCH.
REQ-027 LW (opcode 6'h23) with waitrequest=1 for 2 cycles in FETCH and 3 cycles in EXEC1 -> FETCH x3, DECODE, EXEC1 x4, EXEC2, FETCH; instr_count increments once.
REQ-028 BGEZAL (opcode 1, regimm=5'h11) -> EXEC2 visited; MULT/MFLO with muldiv_busy=1 for 10 cycles -> EXEC1 held 11 cycles; ADDU with muldiv_busy=1 -> no stall.
REQ-029 FETCH with pc=0 and waitrequest=1 -> HALT next cycle, active=0, counters frozen for 20 cycles; a further reset pulse -> FETCH again.
REQ-030 Force instr_count preload to 32'hFFFFFFFF via backdoor, retire one instruction -> instr_count=0; assert reset_n=0 in EXEC1 of a stalled SW -> state=0 asynchronously, counters=0.
